// File: rtl/cajero_automatico.sv
// ATM transaction controller: card detection, strobed 4-digit PIN entry with
// attempt counting and lockout, then one deposit or withdrawal per session.
module cajero_automatico #(
  parameter int N_INTENTOS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TIPO_TRANS,
  input  logic        MONTO_STB,
  input  logic        DIGITO_STB,
  input  logic [3:0]  DIGITO,
  input  logic [15:0] PIN,
  input  logic [31:0] MONTO,
  input  logic [63:0] BALANCE_INICIAL,
  output logic [63:0] BALANCE,
  output logic        BALANCE_ACTUALIZADO,
  output logic        ENTREGAR_DINERO,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO,
  output logic        FONDOS_INSUFICIENTES
);

  localparam int IW = $clog2(N_INTENTOS + 1);

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    INGRESO_PIN,
    VERIFICA_PIN,
    ESPERA_MONTO,
    TRANSACCION,
    BLOQUEADO
  } estado_t;

  estado_t       estado, estado_d;
  logic          digito_stb_q, monto_stb_q;
  logic [15:0]   pin_reg, pin_d;
  logic [1:0]    n_digitos, n_digitos_d;
  logic [IW-1:0] intentos, intentos_d, intentos_inc;
  logic [31:0]   monto_reg, monto_d;
  logic          tipo_reg, tipo_d;
  logic [63:0]   balance_d, monto_ext;
  logic          actualizado_d, entregar_d, pin_incorrecto_d;
  logic          advertencia_d, bloqueo_d, fondos_d;
  logic          digito_ev, monto_ev;

  // One event per strobe, no matter how long the strobe is held.
  assign digito_ev = DIGITO_STB & ~digito_stb_q;
  assign monto_ev  = MONTO_STB & ~monto_stb_q;
  assign monto_ext = {32'b0, monto_reg};

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    estado_d         = estado;
    pin_d            = pin_reg;
    n_digitos_d      = n_digitos;
    intentos_d       = intentos;
    intentos_inc     = intentos + IW'(1);
    monto_d          = monto_reg;
    tipo_d           = tipo_reg;
    balance_d        = BALANCE;
    advertencia_d    = ADVERTENCIA;
    bloqueo_d        = BLOQUEO;
    actualizado_d    = 1'b0;
    entregar_d       = 1'b0;
    pin_incorrecto_d = 1'b0;
    fondos_d         = 1'b0;

    case (estado)
      ESPERA_TARJETA: begin
        if (TARJETA_RECIBIDA) begin
          balance_d     = BALANCE_INICIAL;
          n_digitos_d   = '0;
          intentos_d    = '0;
          advertencia_d = 1'b0;
          estado_d      = INGRESO_PIN;
        end
      end

      INGRESO_PIN: begin
        if (!TARJETA_RECIBIDA) begin
          n_digitos_d   = '0;
          intentos_d    = '0;
          advertencia_d = 1'b0;
          estado_d      = ESPERA_TARJETA;
        end else if (digito_ev) begin
          pin_d       = {pin_reg[11:0], DIGITO};
          n_digitos_d = n_digitos + 2'd1;
          if (n_digitos == 2'd3) estado_d = VERIFICA_PIN;
        end
      end

      VERIFICA_PIN: begin
        if (pin_reg == PIN) begin
          estado_d = ESPERA_MONTO;
        end else begin
          pin_incorrecto_d = 1'b1;
          intentos_d       = intentos_inc;
          n_digitos_d      = '0;
          if (intentos_inc == IW'(N_INTENTOS)) begin
            bloqueo_d = 1'b1;
            estado_d  = BLOQUEADO;
          end else begin
            if (intentos_inc == IW'(N_INTENTOS - 1)) advertencia_d = 1'b1;
            estado_d = INGRESO_PIN;
          end
        end
      end

      ESPERA_MONTO: begin
        if (!TARJETA_RECIBIDA) begin
          n_digitos_d   = '0;
          intentos_d    = '0;
          advertencia_d = 1'b0;
          estado_d      = ESPERA_TARJETA;
        end else if (monto_ev) begin
          monto_d  = MONTO;
          tipo_d   = TIPO_TRANS;
          estado_d = TRANSACCION;
        end
      end

      TRANSACCION: begin
        // Deposits wrap modulo 2^64; withdrawals never drive the balance negative.
        if (!tipo_reg) begin
          balance_d     = BALANCE + monto_ext;
          actualizado_d = 1'b1;
        end else if (monto_ext <= BALANCE) begin
          balance_d     = BALANCE - monto_ext;
          actualizado_d = 1'b1;
          entregar_d    = 1'b1;
        end else begin
          fondos_d = 1'b1;
        end
        estado_d = ESPERA_TARJETA;
      end

      BLOQUEADO: begin
        estado_d = BLOQUEADO;
      end

      default: estado_d = ESPERA_TARJETA;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset here is synchronous, evaluated only at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado               <= ESPERA_TARJETA;
      digito_stb_q         <= 1'b0;
      monto_stb_q          <= 1'b0;
      pin_reg              <= '0;
      n_digitos            <= '0;
      intentos             <= '0;
      monto_reg            <= '0;
      tipo_reg             <= 1'b0;
      BALANCE              <= '0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
    end else begin
      estado               <= estado_d;
      digito_stb_q         <= DIGITO_STB;
      monto_stb_q          <= MONTO_STB;
      pin_reg              <= pin_d;
      n_digitos            <= n_digitos_d;
      intentos             <= intentos_d;
      monto_reg            <= monto_d;
      tipo_reg             <= tipo_d;
      BALANCE              <= balance_d;
      BALANCE_ACTUALIZADO  <= actualizado_d;
      ENTREGAR_DINERO      <= entregar_d;
      PIN_INCORRECTO       <= pin_incorrecto_d;
      ADVERTENCIA          <= advertencia_d;
      BLOQUEO              <= bloqueo_d;
      FONDOS_INSUFICIENTES <= fondos_d;
    end
  end

endmodule

// File: tb/tb_cajero_automatico.sv
// Self-checking bench for cajero_automatico: directed sessions plus random
// sessions checked against a session-level model of account and lock status.
module tb_cajero_automatico;

  localparam int N_INTENTOS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        TARJETA_RECIBIDA = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic        MONTO_STB = 1'b0;
  logic        DIGITO_STB = 1'b0;
  logic [3:0]  DIGITO = '0;
  logic [15:0] PIN = '0;
  logic [31:0] MONTO = '0;
  logic [63:0] BALANCE_INICIAL = '0;
  logic [63:0] BALANCE;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
  logic        ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES;

  always #5 clk = ~clk;

  cajero_automatico #(.N_INTENTOS(N_INTENTOS)) dut (
    .clk(clk), .rst(rst),
    .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
    .MONTO_STB(MONTO_STB), .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO),
    .PIN(PIN), .MONTO(MONTO), .BALANCE_INICIAL(BALANCE_INICIAL),
    .BALANCE(BALANCE), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
    .ENTREGAR_DINERO(ENTREGAR_DINERO), .PIN_INCORRECTO(PIN_INCORRECTO),
    .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES)
  );

  int n_vec = 0;
  int n_err = 0;

  // Session-level reference model.
  logic [63:0] m_balance;
  logic [15:0] m_pin;
  int          m_intentos;
  bit          m_adv, m_bloq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 64'({PIN_INCORRECTO, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES}), 64'd0);
  endtask

  task automatic check_levels(input string tag);
    check({tag, "_adv"}, 64'(ADVERTENCIA), 64'(m_adv));
    check({tag, "_bloq"}, 64'(BLOQUEO), 64'(m_bloq));
    check({tag, "_bal"}, BALANCE, m_balance);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    TARJETA_RECIBIDA = 1'b0;
    DIGITO_STB = 1'b0;
    MONTO_STB = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_balance = '0;
    m_intentos = 0;
    m_adv = 1'b0;
    m_bloq = 1'b0;
    check_quiet("reset_pulses");
    check_levels("reset");
  endtask

  task automatic start_session(input logic [63:0] bal);
    BALANCE_INICIAL = bal;
    TARJETA_RECIBIDA = 1'b1;
    tick();
    if (!m_bloq) begin
      m_balance = bal;
      m_intentos = 0;
      m_adv = 1'b0;
    end
    check_levels("start");
    check_quiet("start_pulses");
  endtask

  task automatic send_digit(input logic [3:0] d, input int len);
    DIGITO = d;
    DIGITO_STB = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      check_quiet("digit_hold");
    end
    DIGITO_STB = 1'b0;
    DIGITO = 4'($urandom);
    tick();
    check_quiet("digit_gap");
  endtask

  task automatic enter_pin(input logic [15:0] p);
    bit wrong;
    for (int i = 0; i < 3; i++) send_digit(p[15-4*i -: 4], $urandom_range(1, 5));
    DIGITO = p[3:0];
    DIGITO_STB = 1'b1;
    tick();
    check("pin_early", 64'(PIN_INCORRECTO), 64'd0);
    DIGITO_STB = 1'b0;
    wrong = !m_bloq && (p != m_pin);
    if (wrong) begin
      m_intentos++;
      if (m_intentos == N_INTENTOS - 1) m_adv = 1'b1;
      if (m_intentos == N_INTENTOS) m_bloq = 1'b1;
    end
    tick();
    check("pin_incorrecto", 64'(PIN_INCORRECTO), 64'(wrong));
    check_levels("pin");
    tick();
    check_quiet("pin_after");
  endtask

  task automatic transact(input bit tipo, input logic [31:0] monto, input bit keep_card);
    bit act, ent, fon;
    logic [63:0] old_bal;
    act = 1'b0; ent = 1'b0; fon = 1'b0;
    old_bal = m_balance;
    if (!m_bloq) begin
      if (!tipo) begin
        m_balance = m_balance + {32'h0, monto};
        act = 1'b1;
      end else if ({32'h0, monto} <= m_balance) begin
        m_balance = m_balance - {32'h0, monto};
        act = 1'b1;
        ent = 1'b1;
      end else begin
        fon = 1'b1;
      end
    end
    TIPO_TRANS = tipo;
    MONTO = monto;
    MONTO_STB = 1'b1;
    tick();
    check("tx_early_bal", BALANCE, old_bal);
    check_quiet("tx_early");
    if (!keep_card) TARJETA_RECIBIDA = 1'b0;
    MONTO = $urandom;
    TIPO_TRANS = 1'($urandom);
    tick();
    check("tx_actualizado", 64'(BALANCE_ACTUALIZADO), 64'(act));
    check("tx_entregar", 64'(ENTREGAR_DINERO), 64'(ent));
    check("tx_fondos", 64'(FONDOS_INSUFICIENTES), 64'(fon));
    check_levels("tx");
    if (keep_card && !m_bloq) begin
      tick();
      m_balance = BALANCE_INICIAL;
      m_intentos = 0;
      m_adv = 1'b0;
      check_levels("reload");
      check_quiet("reload_pulses");
      TARJETA_RECIBIDA = 1'b0;
    end
    MONTO_STB = 1'b0;
    tick();
    check_quiet("tx_after");
    tick();
  endtask

  function automatic logic [15:0] rand_pin();
    logic [15:0] p = '0;
    for (int i = 0; i < 4; i++) p = {p[11:0], 4'($urandom_range(0, 9))};
    return p;
  endfunction

  initial begin
    logic [15:0] w;
    logic [63:0] bal;
    logic [31:0] monto;

    m_pin = 16'h3761;
    PIN = m_pin;
    do_reset();

    // Deposit with a 2-cycle amount strobe.
    start_session(64'd10000);
    enter_pin(16'h3761);
    transact(1'b0, 32'd2000, 1'b0);
    check("deposit_bal", BALANCE, 64'd12000);

    // Withdrawal, then insufficient funds.
    start_session(64'd10000);
    enter_pin(16'h3761);
    transact(1'b1, 32'd2000, 1'b0);
    check("withdraw_bal", BALANCE, 64'd8000);
    start_session(64'd1000);
    enter_pin(16'h3761);
    transact(1'b1, 32'd2000, 1'b0);
    check("nofunds_bal", BALANCE, 64'd1000);

    // Lockout; a correct PIN and an amount afterwards are ignored.
    do_reset();
    start_session(64'd5000);
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    enter_pin(16'h4444);
    enter_pin(16'h3761);
    transact(1'b0, 32'd100, 1'b0);
    check("locked_bal", BALANCE, 64'd5000);
    do_reset();

    // Wrong then right, deposit of zero.
    start_session(64'd7000);
    enter_pin(16'h1111);
    enter_pin(16'h3761);
    transact(1'b0, 32'd0, 1'b0);

    // Abort after two digits (first held 5 cycles), including a pending warning.
    start_session(64'd500);
    enter_pin(16'h1111);
    enter_pin(16'h9999);
    send_digit(4'd3, 5);
    send_digit(4'd7, 1);
    TARJETA_RECIBIDA = 1'b0;
    m_intentos = 0;
    m_adv = 1'b0;
    tick();
    check_quiet("abort_pulses");
    tick();
    check_quiet("abort_pulses2");
    check_levels("abort");
    start_session(64'd600);
    enter_pin(16'h3761);
    transact(1'b0, 32'd50, 1'b0);

    // Exact-balance withdrawal, wrapping deposit with a card held for reload.
    start_session(64'd4242);
    enter_pin(16'h3761);
    transact(1'b1, 32'd4242, 1'b0);
    check("exact_bal", BALANCE, 64'd0);
    start_session(64'hFFFF_FFFF_FFFF_FF00);
    enter_pin(16'h3761);
    transact(1'b0, 32'h200, 1'b1);

    // Random sessions.
    for (int s = 0; s < 40; s++) begin
      m_pin = rand_pin();
      PIN = m_pin;
      bal = ($urandom_range(0, 1) == 0) ? {32'h0, 32'($urandom)} : {32'($urandom), 32'($urandom)};
      start_session(bal);
      if ($urandom_range(0, 4) == 0) begin
        send_digit(4'($urandom_range(0, 9)), $urandom_range(1, 5));
        TARJETA_RECIBIDA = 1'b0;
        m_intentos = 0;
        m_adv = 1'b0;
        tick();
        tick();
        check_quiet("rnd_abort");
        check_levels("rnd_abort");
        continue;
      end
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        w = rand_pin();
        if (w == m_pin) w = w ^ 16'h0001;
        enter_pin(w);
      end
      case ($urandom_range(0, 3))
        0: monto = $urandom;
        1: monto = bal[31:0];
        2: monto = bal[31:0] + 32'd1;
        default: monto = '0;
      endcase
      if (m_bloq) begin
        enter_pin(m_pin);
        transact(1'($urandom), monto, 1'b0);
        do_reset();
      end else begin
        enter_pin(m_pin);
        transact(1'($urandom), monto, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
